store_buf_drain: RTL and testbench
==================================

Name: store_buf_drain

Overview:
- Reader side of the store ring buffer: holds committed stores (address, word data, byte strobe) in FIFO order and drains them to data memory over the SRAM-like write interface (req/addr_ok/data_ok).
- Sits between the MEM-stage store commit and the data-side cache/bridge.
- Also answers a combinational address-match query so loads can stall on pending stores.

Parameters:
- BUF_LENGTH, 8, number of entries (any value >= 2, power of two not required).
- BUF_LENGTH_BITS, $clog2(BUF_LENGTH), pointer width.
- ADDR_WIDTH, 32, byte address width.
- Data width is fixed at 32 bits with 4 byte strobes.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  store push request.
- in_ready  out  1  buffer can accept a push.
- in_addr  in  ADDR_WIDTH  store byte address; bits [1:0] are ignored.
- in_data  in  32  store word, byte-lane aligned.
- in_strb  in  4  byte enables.
- mem_req  out  1  write request to memory.
- mem_wr  out  1  constant 1.
- mem_size  out  2  0 = byte, 1 = half, 2 = word.
- mem_addr  out  ADDR_WIDTH  write byte address.
- mem_wdata  out  32  write data.
- mem_addr_ok  in  1  request accepted.
- mem_data_ok  in  1  oldest accepted write completed.
- query_addr  in  ADDR_WIDTH  load address to check.
- query_hit  out  1  a held entry matches query_addr word.
- count  out  BUF_LENGTH_BITS+1  entries held.
- empty  out  1  count == 0.
- err  out  1  sticky protocol/strobe error.

Behaviour:
- Storage: BUF_LENGTH entries of {addr word, data, strb}. The block keeps three pointers:
  - wr_ptr: next slot to fill.
  - iss_ptr: next entry to send.
  - ret_ptr: oldest un-retired entry.
- It also keeps a counter `count` (entries held) and `outst` (issued but not retired).
- Pointer wrap: each pointer goes from BUF_LENGTH-1 to 0 on advance.
- Reset (async, any time, including mid-transaction):
  - all pointers, count and outst clear to 0.
  - err clears to 0 and mem_req drops to 0 immediately.
  - Immediately after reset: in_ready = 1, empty = 1, query_hit = 0.
  - Any in-flight write is abandoned; a later stray data_ok is treated as an error (see below).
- Push:
  - in_ready = (count != BUF_LENGTH), driven from registers only.
  - On clk with in_valid && in_ready: the entry is written at wr_ptr and wr_ptr advances.
- Issue:
  - mem_req = (count - outst) != 0. mem_addr, mem_size and mem_wdata come from the entry at iss_ptr.
  - The entry stays stable while mem_req is high and addr_ok is low.
  - On mem_req && mem_addr_ok: iss_ptr advances and outst increments.
  - Latency from push handshake to first mem_req is 1 cycle; a store pushed into an empty buffer is never issued in the same cycle.
- Size/address encoding from strb:
  - 1111 -> size 2, addr[1:0] = 00.
  - 0011 -> size 1, 00.
  - 1100 -> size 1, 10.
  - one-hot bit k -> size 0, addr[1:0] = k.
  - Any other pattern, including 0000, -> size 2, addr[1:0] = 00, and err sets on issue.
- Retire:
  - On mem_data_ok with outst != 0: ret_ptr advances, outst decrements, count decrements.
  - mem_data_ok with outst == 0 is ignored and sets err.
- Simultaneous events in one cycle:
  - push + retire: count unchanged.
  - addr_ok + data_ok: outst unchanged.
  - All three together are legal.
  - A full buffer with retire in the same cycle still reports in_ready = 0 that cycle (no combinational ready path).
- query_hit: combinational OR over all held entries (both issued and un-issued, i.e. ret_ptr up to but not including wr_ptr) of addr[ADDR_WIDTH-1:2] == query_addr[ADDR_WIDTH-1:2]. It is 0 when empty.
- Invariant: 0 <= outst <= count <= BUF_LENGTH.

Test Plan:
- Reset, then push {addr 0x1000, data 0xAABBCCDD, strb 1111}:
  - next cycle mem_req = 1, addr 0x1000, size 2.
  - addr_ok then data_ok -> count 0, empty = 1.
- Push strb 0100 at addr 0x2003 -> mem_addr 0x2002, size 0. Push strb 1100 -> mem_addr 0x2002, size 1. Push strb 0101 -> size 2 and err = 1.
- Fill 8 entries with addr_ok held low:
  - in_ready = 0 at count 8 and a 9th in_valid is ignored.
  - Drain all entries; issue order and wrap through slot 7 -> 0 match push order.
- With count 8, push and data_ok in the same cycle:
  - the push is rejected.
  - the next cycle count = 7 and in_ready = 1.
- Steady state: push, addr_ok and data_ok every cycle -> count stays constant and no entry is lost or duplicated across 20 stores.
- Query and error corner cases:
  - Pending entry at 0x3008: query 0x300A -> hit = 1; query 0x300C -> hit = 0.
  - Assert reset mid-issue -> mem_req falls immediately and query_hit = 0.
  - A stray data_ok afterwards -> err = 1.

Source files
------------

// File: rtl/store_buf_drain.sv
// Store ring buffer reader: holds committed stores in FIFO order and drains them
// over an SRAM-like write port (req/addr_ok/data_ok), with a load address-match query.
module store_buf_drain #(
   parameter int BUF_LENGTH      = 8,
   parameter int BUF_LENGTH_BITS = $clog2(BUF_LENGTH),
   parameter int ADDR_WIDTH      = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_WIDTH-1:0]    in_addr,
   input  logic [31:0]              in_data,
   input  logic [3:0]               in_strb,
   output logic                     mem_req,
   output logic                     mem_wr,
   output logic [1:0]               mem_size,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   output logic [31:0]              mem_wdata,
   input  logic                     mem_addr_ok,
   input  logic                     mem_data_ok,
   input  logic [ADDR_WIDTH-1:0]    query_addr,
   output logic                     query_hit,
   output logic [BUF_LENGTH_BITS:0] count,
   output logic                     empty,
   output logic                     err
);

   localparam int CW = BUF_LENGTH_BITS + 1;
   localparam logic [CW-1:0] LEN = CW'(BUF_LENGTH);
   localparam logic [BUF_LENGTH_BITS-1:0] LAST = BUF_LENGTH_BITS'(BUF_LENGTH - 1);

   logic [ADDR_WIDTH-3:0]       addr_q [BUF_LENGTH];
   logic [31:0]                 data_q [BUF_LENGTH];
   logic [3:0]                  strb_q [BUF_LENGTH];

   logic [BUF_LENGTH_BITS-1:0]  wr_ptr, iss_ptr, ret_ptr;
   logic [CW-1:0]               outst;
   logic                        push, issue, retire, stray;
   logic [3:0]                  iss_strb;
   logic [1:0]                  addr_lo;
   logic                        strb_bad;
   logic [BUF_LENGTH-1:0]       hit_vec;
   logic [CW-1:0]               rp;
   logic                        unused_lo;

   function automatic logic [BUF_LENGTH_BITS-1:0] adv(input logic [BUF_LENGTH_BITS-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign unused_lo = ^{in_addr[1:0], query_addr[1:0]};

   assign in_ready = (count != LEN);
   assign mem_req  = (count != outst);
   assign mem_wr   = 1'b1;
   assign empty    = (count == '0);

   assign push   = in_valid && in_ready;
   assign issue  = mem_req && mem_addr_ok;
   assign retire = mem_data_ok && (outst != '0);
   assign stray  = mem_data_ok && (outst == '0);

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= in_addr[ADDR_WIDTH-1:2];
         data_q[wr_ptr] <= in_data;
         strb_q[wr_ptr] <= in_strb;
      end
   end

   // Byte strobe -> transfer size and low address bits; illegal patterns go out as a word.
   always_comb begin
      iss_strb = strb_q[iss_ptr];
      mem_size = 2'd2;
      addr_lo  = 2'b00;
      strb_bad = 1'b0;
      case (iss_strb)
         4'b1111: ;
         4'b0011: mem_size = 2'd1;
         4'b1100: begin mem_size = 2'd1; addr_lo = 2'b10; end
         4'b0001: begin mem_size = 2'd0; addr_lo = 2'b00; end
         4'b0010: begin mem_size = 2'd0; addr_lo = 2'b01; end
         4'b0100: begin mem_size = 2'd0; addr_lo = 2'b10; end
         4'b1000: begin mem_size = 2'd0; addr_lo = 2'b11; end
         default: strb_bad = 1'b1;
      endcase
   end

   assign mem_addr  = {addr_q[iss_ptr], addr_lo};
   assign mem_wdata = data_q[iss_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         iss_ptr <= '0;
         ret_ptr <= '0;
         count   <= '0;
         outst   <= '0;
         err     <= 1'b0;
      end else begin
         if (push)   wr_ptr  <= adv(wr_ptr);
         if (issue)  iss_ptr <= adv(iss_ptr);
         if (retire) ret_ptr <= adv(ret_ptr);
         count <= count + CW'(push) - CW'(retire);
         outst <= outst + CW'(issue) - CW'(retire);
         if ((issue && strb_bad) || stray) err <= 1'b1;
      end
   end

   // An entry is held when its distance from ret_ptr (modulo the ring) is below count.
   assign rp = {1'b0, ret_ptr};
   for (genvar i = 0; i < BUF_LENGTH; i++) begin : g_hit
      localparam logic [CW-1:0] IDX = CW'(i);
      logic [CW-1:0] off;
      assign off        = (IDX >= rp) ? (IDX - rp) : (IDX + LEN - rp);
      assign hit_vec[i] = (off < count) && (addr_q[i] == query_addr[ADDR_WIDTH-1:2]);
   end

   assign query_hit = |hit_vec;

endmodule

// File: tb/tb_store_buf_drain.sv
// Directed bench for store_buf_drain: issue encoding, full/wrap handling,
// steady-state streaming, query match and async reset corner cases.
module tb_store_buf_drain;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [3:0]  in_strb;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] query_addr;
   logic        query_hit;
   logic [3:0]  count;
   logic        empty, err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   store_buf_drain dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .in_strb(in_strb),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .query_addr(query_addr), .query_hit(query_hit), .count(count),
      .empty(empty), .err(err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      in_valid = 1'b1; in_addr = a; in_data = d; in_strb = s;
      step();
      in_valid = 1'b0;
   endtask

   task automatic issue_retire();
      mem_addr_ok = 1'b1;
      step();
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      step();
      mem_data_ok = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; in_strb = '0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; query_addr = 32'h1000;
      step();
      chk("rst_ready", in_ready, 1);
      chk("rst_empty", empty, 1);
      chk("rst_hit", query_hit, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_err", err, 0);
      chk("rst_count", count, 0);
      step();
      reset = 1'b0;

      // basic word store
      in_valid = 1'b1; in_addr = 32'h1000; in_data = 32'hAABBCCDD; in_strb = 4'b1111;
      #1 chk("no_same_cycle_req", mem_req, 0);
      step();
      in_valid = 1'b0;
      chk("w_req", mem_req, 1);
      chk("w_addr", mem_addr, 32'h1000);
      chk("w_size", mem_size, 2);
      chk("w_data", mem_wdata, 32'hAABBCCDD);
      chk("w_wr", mem_wr, 1);
      mem_addr_ok = 1'b1;
      step();
      mem_addr_ok = 1'b0;
      chk("w_req_after_aok", mem_req, 0);
      chk("w_count_outst", count, 1);
      mem_data_ok = 1'b1;
      step();
      mem_data_ok = 1'b0;
      chk("w_count_done", count, 0);
      chk("w_empty", empty, 1);
      chk("w_err", err, 0);

      // strobe encodings
      push1(32'h2003, 32'h00110000, 4'b0100);
      chk("b_addr", mem_addr, 32'h2002);
      chk("b_size", mem_size, 0);
      issue_retire();
      push1(32'h2003, 32'h22330000, 4'b1100);
      chk("h_addr", mem_addr, 32'h2002);
      chk("h_size", mem_size, 1);
      issue_retire();
      chk("h_err", err, 0);
      push1(32'h2003, 32'h44005500, 4'b0101);
      chk("bad_size", mem_size, 2);
      chk("bad_addr", mem_addr, 32'h2000);
      chk("bad_err_pre", err, 0);
      issue_retire();
      chk("bad_err", err, 1);

      // fill from slot 4 so the ring wraps through 7 -> 0
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_addr = 32'h4000 + 4 * i; in_data = 32'h11110000 + i; in_strb = 4'hF;
         step();
      end
      in_addr = 32'h4FF0; in_data = 32'hDEADBEEF;
      #1;
      chk("full_ready", in_ready, 0);
      chk("full_count", count, 8);
      chk("full_head", mem_addr, 32'h4000);
      step();
      in_valid = 1'b0;
      chk("ninth_ignored", count, 8);
      mem_addr_ok = 1'b1;
      step();
      mem_addr_ok = 1'b0;
      in_valid = 1'b1; mem_data_ok = 1'b1;
      #1 chk("full_retire_ready", in_ready, 0);
      step();
      in_valid = 1'b0; mem_data_ok = 1'b0;
      chk("after_retire_count", count, 7);
      chk("after_retire_ready", in_ready, 1);
      for (int k = 1; k < 8; k++) begin
         chk($sformatf("drain_addr%0d", k), mem_addr, 32'h4000 + 4 * k);
         chk($sformatf("drain_data%0d", k), mem_wdata, 32'h11110000 + k);
         issue_retire();
      end
      chk("drain_empty", empty, 1);
      chk("drain_req", mem_req, 0);

      // steady state: push, addr_ok and data_ok every cycle
      do_reset();
      chk("ss_err_clr", err, 0);
      push1(32'h5000, 32'hC0DE0000, 4'hF);
      in_valid = 1'b1; in_addr = 32'h5004; in_data = 32'hC0DE0001; mem_addr_ok = 1'b1;
      step();
      for (int n = 2; n < 20; n++) begin
         in_addr = 32'h5000 + 4 * n; in_data = 32'hC0DE0000 + n; mem_data_ok = 1'b1;
         #1;
         chk($sformatf("ss_addr%0d", n - 1), mem_addr, 32'h5000 + 4 * (n - 1));
         chk($sformatf("ss_count%0d", n), count, 2);
         step();
      end
      in_valid = 1'b0;
      #1 chk("ss_last_addr", mem_addr, 32'h504C);
      step();
      mem_addr_ok = 1'b0;
      chk("ss_tail_count", count, 1);
      step();
      mem_data_ok = 1'b0;
      chk("ss_final_count", count, 0);
      chk("ss_err", err, 0);

      // query match and async reset mid-issue
      query_addr = 32'h3008;
      #1 chk("q_empty_hit", query_hit, 0);
      push1(32'h3008, 32'h12345678, 4'hF);
      query_addr = 32'h300A;
      #1 chk("q_hit", query_hit, 1);
      query_addr = 32'h300C;
      #1 chk("q_miss", query_hit, 0);
      query_addr = 32'h3008;
      mem_addr_ok = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_req", mem_req, 0);
      chk("rst_mid_hit", query_hit, 0);
      chk("rst_mid_ready", in_ready, 1);
      mem_addr_ok = 1'b0;
      step();
      reset = 1'b0;
      chk("rst_mid_err", err, 0);
      mem_data_ok = 1'b1;
      step();
      mem_data_ok = 1'b0;
      chk("stray_err", err, 1);
      chk("stray_count", count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
